// File: rtl/viterbi_pkg.sv
// Shared constants and types for the rate-1/2 convolutional encoder and the Viterbi decoder.
package viterbi_pkg;

    localparam int unsigned K         = 3;
    localparam logic [K-1:0] G0       = 3'b111;
    localparam logic [K-1:0] G1       = 3'b101;
    localparam int unsigned FRAME_LEN = 256;

    typedef logic [1:0] codeword_t;

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } enc_state_t;

    // Parity of the tapped register bits.
    function automatic logic parity(input logic [K-1:0] r, input logic [K-1:0] g);
        return ^(r & g);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder core: K-1 bit shift register and the two generator parities.
module conv_enc_core
    import viterbi_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      shift_en,
    input  logic      u,
    output codeword_t cw_c
);

    // sr[K-2] holds the most recent bit (s1), sr[0] the oldest.
    logic [K-2:0] sr;
    logic [K-1:0] r_c;

    assign r_c  = {u, sr};
    assign cw_c = {parity(r_c, G0), parity(r_c, G1)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= (K-1)'(r_c >> 1);
        end
    end

endmodule

// File: rtl/conv_enc_framer.sv
// Framed convolutional encoder: FRAME_BITS data bits followed by K-1 zero tail bits.
module conv_enc_framer
    import viterbi_pkg::*;
#(
    parameter int unsigned FRAME_BITS = viterbi_pkg::FRAME_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       ready_o,
    output logic       valid_o,
    output logic [1:0] d_out,
    output logic       sof_o,
    output logic       eof_o
);

    localparam int unsigned BCW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int unsigned TCW = $clog2(K);

    enc_state_t     state;
    logic [BCW-1:0] bit_cnt;
    logic [TCW-1:0] tail_cnt;

    logic      accept_c;
    logic      shift_c;
    logic      u_c;
    codeword_t cw_c;

    assign accept_c = enable_i && ready_o && (state == DATA);
    assign shift_c  = accept_c || (state == TAIL);
    assign u_c      = (state == DATA) ? d_in : 1'b0;

    conv_enc_core u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_c),
        .u        (u_c),
        .cw_c     (cw_c)
    );

    // Frame FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DATA;
            bit_cnt  <= '0;
            tail_cnt <= '0;
            ready_o  <= 1'b0;
            valid_o  <= 1'b0;
            d_out    <= 2'b00;
            sof_o    <= 1'b0;
            eof_o    <= 1'b0;
        end else begin
            valid_o <= shift_c;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
            if (shift_c) begin
                d_out <= cw_c;
            end
            case (state)
                DATA: begin
                    ready_o <= 1'b1;
                    if (accept_c) begin
                        sof_o <= (bit_cnt == '0);
                        if (bit_cnt == BCW'(FRAME_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= TAIL;
                            ready_o <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                TAIL: begin
                    ready_o <= 1'b0;
                    if (tail_cnt == TCW'(K - 2)) begin
                        tail_cnt <= '0;
                        state    <= DATA;
                        ready_o  <= 1'b1;
                        eof_o    <= 1'b1;
                    end else begin
                        tail_cnt <= tail_cnt + TCW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/conv_enc_framer.md
Name: conv_enc_framer

Overview:
- Rate-1/2 feed-forward convolutional encoder with frame termination. Sits directly upstream of the Viterbi decoder path, ahead of the channel error-injection stage.
- Accepts one information bit per handshake and emits one 2-bit codeword per cycle with a valid strobe.
- After every FRAME_LEN data bits it appends K-1 zero tail bits, so each frame ends in state 0 for the traceback.

Parameters:
- K, 3: constraint length. Shift register holds K-1 bits.
- G0, 3'b111: generator polynomial for d_out[1]. MSB taps the current input bit.
- G1, 3'b101: generator polynomial for d_out[0]. MSB taps the current input bit.
- FRAME_LEN, 256: information bits per frame. Legal values are >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- enable_i  in  1  input bit valid
- d_in  in  1  information bit
- ready_o  out  1  block can accept a bit this cycle
- valid_o  out  1  d_out holds a new codeword this cycle
- d_out  out  2  codeword {G0 parity, G1 parity}
- sof_o  out  1  high with the first codeword of a frame
- eof_o  out  1  high with the last tail codeword of a frame

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. While rst is low:
  - shift register = 0, bit counter = 0, tail counter = 0, state = DATA.
  - valid_o = 0, d_out = 2'b00, sof_o = 0, eof_o = 0.
  - ready_o = 0 while in reset, then 1 on the first clk edge after release.
- Reset asserted mid-frame: everything clears immediately. The partial frame is discarded and no tail is emitted.
- Accept rule: a bit is taken on a rising edge when enable_i && ready_o. enable_i while ready_o = 0 is ignored. The producer must hold the bit.
- No downstream backpressure: the consumer always takes d_out when valid_o is high.
- Encoding:
  - Register vector r = {u, s1, s2}. u is the current bit, s1 the previous bit, s2 the one before.
  - d_out[1] = XOR-reduce(r & G0). d_out[0] = XOR-reduce(r & G1).
  - After each encoded bit: s2 <= s1, s1 <= u.
- Latency: registered output. A codeword appears one cycle after its bit is accepted. Throughput is 1 bit per cycle.
- valid_o is high for exactly one cycle per encoded bit (data or tail) and low otherwise.
- FSM:
  - DATA: ready_o = 1. Each accepted bit increments the bit counter.
    - On the accept that makes the count FRAME_LEN: counter -> 0, next state TAIL, and ready_o drops in the following cycle.
  - TAIL: ready_o = 0. Encodes u = 0 every cycle, whatever enable_i is. Runs for exactly K-1 cycles using a tail counter.
    - On the last tail cycle, next state is DATA, and ready_o returns 1 the cycle after the last tail bit is encoded.
- Back-to-back frames: with enable_i held high continuously, the pattern is FRAME_LEN accepted bits, K-1 idle-input cycles, then the next frame.
- sof_o is co-timed with valid_o for the codeword of data bit 0 of each frame.
- eof_o is co-timed with valid_o for the codeword of the final tail bit.
- Shift register after a completed frame is always 0. Assert this in the bench.
- Counter widths:
  - bit counter is $clog2(FRAME_LEN) bits and wraps FRAME_LEN-1 -> 0.
  - tail counter is $clog2(K) bits.
- enable_i low mid-frame: no state change and valid_o = 0. Gaps of any length are allowed.

Decomposition:
- Package viterbi_pkg holds:
  - constants K, G0, G1, FRAME_LEN;
  - typedef codeword_t = logic [1:0];
  - typedef enum {DATA, TAIL} enc_state_t.
  - The decoder imports the same package so the polynomials match.
- One sub-module, conv_enc_core:
  - purely the K-1 bit shift register plus the parity logic;
  - inputs: shift enable and bit u; output: codeword.
  - The framer owns the FSM, counters, handshake and output registers.

Test Plan:
- K=3, G0=111, G1=101, FRAME_LEN=4. Apply rst low, then high, with enable_i=1 and d_in sequence 1,0,1,1.
  - Required: codewords 11,10,00,01, each one cycle after its accept.
  - Then tail codewords 01,11.
  - sof_o on the first 11, eof_o on the final 11.
  - ready_o low for 2 cycles.
- Continuous enable_i=1 across 3 frames of all-zero input. Required:
  - all codewords = 00;
  - valid_o high 6 of every 6 cycles;
  - ready_o pattern 1,1,1,1,0,0 repeating;
  - shift register = 0 at each eof_o.
- Data bits 1,0,1,1 delivered with enable_i gaps of 0–3 random cycles. Required: the same codeword sequence as the first scenario, and valid_o low in every gap cycle.
- enable_i=1 with d_in=1 held during TAIL. Required: tail codewords are still 01,11, and no extra data bit is counted in the next frame.
- Assert rst low after 2 data bits of a frame. Required:
  - valid_o, d_out, sof_o and eof_o go to 0 asynchronously.
  - After release, a new frame starts with sof_o; input 1 gives codeword 11.
- FRAME_LEN=256 with random bits, checked against a reference model: 258 codewords per frame, exactly one sof_o and one eof_o per frame.
